bg_index_fetcher: RTL and testbench



---
 rtl/bg_index_fetcher_if.sv | 37 +++
 rtl/bg_index_fetcher.sv | 129 ++++++++++++
 tb/tb_bg_index_fetcher.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bg_index_fetcher_if.sv
// Pixel-in / ROM-bus / index-out bundle for bg_index_fetcher.
// scroll_x exists only when BG_SCROLL_EN is defined.
`timescale 1ns/1ps
interface bg_index_fetcher_if #(
  parameter int unsigned ID_W = 6
);
  logic              pixel_en;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
`ifdef BG_SCROLL_EN
  logic [9:0]        scroll_x;
`endif
  logic [10:0]       map_addr;
  logic [ID_W-1:0]   map_data;
  logic [ID_W+7:0]   tile_addr;
  logic [7:0]        tile_data;
  logic [7:0]        bgColor;
  logic              bg_valid;
  logic [9:0]        OutX;
  logic [9:0]        OutY;

  modport master (
`ifdef BG_SCROLL_EN
    input  scroll_x,
`endif
    input  pixel_en, DrawX, DrawY, map_data, tile_data,
    output map_addr, tile_addr, bgColor, bg_valid, OutX, OutY
  );

  modport slave (
`ifdef BG_SCROLL_EN
    output scroll_x,
`endif
    output pixel_en, DrawX, DrawY, map_data, tile_data,
    input  map_addr, tile_addr, bgColor, bg_valid, OutX, OutY
  );
endinterface

// File: rtl/bg_index_fetcher.sv
// Background palette-index fetcher: DrawX/DrawY -> tile-map ROM -> pixel ROM -> bgColor, 3-Clk latency.
// Optional horizontal scrolling with frame-start latched scroll_x when BG_SCROLL_EN is defined.
`timescale 1ns/1ps
module bg_index_fetcher #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned TILE_SHIFT = 4,
  parameter int unsigned MAP_W      = 40,
  parameter int unsigned ID_W       = 6,
  parameter logic [7:0]  BORDER_IDX = 8'h00
) (
  input  logic             Clk,
  input  logic             Reset,
  bg_index_fetcher_if.master bus
);

  localparam int unsigned TW    = 10 - TILE_SHIFT;
  localparam logic [9:0]  H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  // Constant-coefficient shift-add: ty*MAP_W without a multiplier (40 -> (ty<<5)+(ty<<3)).
  function automatic logic [10:0] row_base(input logic [TW-1:0] ty);
    logic [10:0] acc;
    acc = '0;
    for (int i = 0; i < 11; i++) begin
      if (MAP_W[i]) acc = acc + (11'(ty) << i);
    end
    return acc;
  endfunction

  logic [9:0]            fetch_x;
  logic                  act_s0, fetch_s0;
  logic [10:0]           map_calc, map_addr_q, map_addr_nx;

  logic                  vld_p0, vld_p1, vld_p2;
  logic [9:0]            x_p0, y_p0, x_p1, y_p1;
  logic [TILE_SHIFT-1:0] fx_p0;
  logic                  act_p0, act_p1;

  logic                  fetch_s1;
  logic [ID_W+7:0]       tile_addr_q, tile_addr_nx;

  logic [7:0]            bg_color_p2;
  logic [9:0]            out_x_p2, out_y_p2;

`ifdef BG_SCROLL_EN
  logic [9:0]  scroll_reg, scroll_red, scroll_use;
  logic [10:0] sum_x;
  logic        frame_start;

  assign scroll_red  = (bus.scroll_x >= H_LIM) ? bus.scroll_x - H_LIM : bus.scroll_x;
  assign frame_start = bus.pixel_en && (bus.DrawX == '0) && (bus.DrawY == '0);
  // The frame's first pixel already uses the newly latched value.
  assign scroll_use  = frame_start ? scroll_red : scroll_reg;
  assign sum_x       = {1'b0, bus.DrawX} + {1'b0, scroll_use};
  assign fetch_x     = (sum_x >= {1'b0, H_LIM}) ? 10'(sum_x - {1'b0, H_LIM}) : sum_x[9:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      scroll_reg <= '0;
    end else if (frame_start) begin
      scroll_reg <= scroll_red;
    end
  end
`else
  assign fetch_x = bus.DrawX;
`endif

  // S0: map ROM address straight from the strobe; held on blanking/idle so the ROM stays quiet
  assign act_s0      = (bus.DrawX < H_LIM) && (bus.DrawY < V_LIM);
  assign fetch_s0    = bus.pixel_en && act_s0 && !Reset;
  assign map_calc    = row_base(bus.DrawY[9:TILE_SHIFT]) + 11'(fetch_x[9:TILE_SHIFT]);
  assign map_addr_nx = fetch_s0 ? map_calc : map_addr_q;
  assign bus.map_addr = map_addr_nx;

  // S1: map_data valid, pixel ROM address formed from it
  assign fetch_s1     = vld_p0 && act_p0 && !Reset;
  assign tile_addr_nx = fetch_s1 ? {bus.map_data, y_p0[TILE_SHIFT-1:0], fx_p0} : tile_addr_q;
  assign bus.tile_addr = tile_addr_nx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      map_addr_q  <= '0;
      tile_addr_q <= '0;
    end else begin
      vld_p0      <= bus.pixel_en;
      vld_p1      <= vld_p0;
      vld_p2      <= vld_p1;
      map_addr_q  <= map_addr_nx;
      tile_addr_q <= tile_addr_nx;
    end
  end

  always_ff @(posedge Clk) begin
    if (bus.pixel_en) begin
      x_p0   <= bus.DrawX;
      y_p0   <= bus.DrawY;
      fx_p0  <= fetch_x[TILE_SHIFT-1:0];
      act_p0 <= act_s0;
    end
    if (vld_p0) begin
      x_p1   <= x_p0;
      y_p1   <= y_p0;
      act_p1 <= act_p0;
    end
  end

  // S2: tile_data valid, register the output index and aligned coordinates
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bg_color_p2 <= '0;
      out_x_p2    <= '0;
      out_y_p2    <= '0;
    end else if (vld_p1) begin
      bg_color_p2 <= act_p1 ? bus.tile_data : BORDER_IDX;
      out_x_p2    <= x_p1;
      out_y_p2    <= y_p1;
    end
  end

  assign bus.bgColor  = bg_color_p2;
  assign bus.bg_valid = vld_p2;
  assign bus.OutX     = out_x_p2;
  assign bus.OutY     = out_y_p2;

endmodule

// File: tb/tb_bg_index_fetcher.sv
// Directed bench for bg_index_fetcher with behavioural synchronous map/pixel ROMs.
// Scroll steps are included when BG_SCROLL_EN is defined.
`timescale 1ns/1ps
module tb_bg_index_fetcher;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [5:0] map_rom [0:2047];
  logic [7:0] pix_rom [0:16383];

  bg_index_fetcher_if #(.ID_W(6)) bus ();

  bg_index_fetcher dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.map_data  <= map_rom[bus.map_addr];
    bus.tile_data <= pix_rom[bus.tile_addr];
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ma_of(input int x, input int y);
    return 11'((y / 16) * 40 + (x / 16));
  endfunction

  function automatic logic [13:0] ta_of(input int x, input int y);
    logic [3:0] yl, xl;
    yl = 4'(y % 16);
    xl = 4'(x % 16);
    return {map_rom[ma_of(x, y)], yl, xl};
  endfunction

  function automatic logic [7:0] col_of(input int x, input int y);
    return pix_rom[ta_of(x, y)];
  endfunction

  // Drive one isolated pixel and follow it to the output.
  task automatic pix1(input logic [9:0] x, input logic [9:0] y, input logic [10:0] exp_ma,
                      input logic [13:0] exp_ta, input logic [7:0] exp_c);
    @(negedge clk);
    bus.pixel_en = 1'b1; bus.DrawX = x; bus.DrawY = y;
    #1 chk("map_addr", 32'(bus.map_addr), 32'(exp_ma));
    @(negedge clk);
    bus.pixel_en = 1'b0;
    #1 chk("tile_addr", 32'(bus.tile_addr), 32'(exp_ta));
    chk("bg_valid_c1", 32'(bus.bg_valid), 0);
    @(negedge clk);
    #1 chk("bg_valid_c2", 32'(bus.bg_valid), 0);
    @(negedge clk);
    #1 chk("bg_valid_c3", 32'(bus.bg_valid), 1);
    chk("bgColor", 32'(bus.bgColor), 32'(exp_c));
    chk("OutX", 32'(bus.OutX), 32'(x));
    chk("OutY", 32'(bus.OutY), 32'(y));
    @(negedge clk);
    #1 chk("bg_valid_c4", 32'(bus.bg_valid), 0);
    chk("bgColor_hold", 32'(bus.bgColor), 32'(exp_c));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 2048; i++) map_rom[i] = 6'((i * 7 + 5) % 64);
    for (int a = 0; a < 16384; a++) pix_rom[a] = 8'((a * 13 + 7) % 256);
    pix_rom[14'h500] = 8'h2A;

    rst = 1'b1;
    bus.pixel_en = 1'b0;
    bus.DrawX = '0;
    bus.DrawY = '0;
`ifdef BG_SCROLL_EN
    bus.scroll_x = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bg_valid", 32'(bus.bg_valid), 0);
    chk("rst_bgColor", 32'(bus.bgColor), 0);
    chk("rst_OutX", 32'(bus.OutX), 0);
    chk("rst_OutY", 32'(bus.OutY), 0);
    chk("rst_map_addr", 32'(bus.map_addr), 0);
    chk("rst_tile_addr", 32'(bus.tile_addr), 0);
    rst = 1'b0;

    // Single pixel at origin: tile 5, index 0x2A
    pix1(10'd0, 10'd0, 11'd0, 14'h500, 8'h2A);

    // Bottom-right corner: map row 29, col 39; map_rom[1199]=14; pix_rom[0xEFF]=0xFA
    pix1(10'd639, 10'd479, 11'd1199, 14'h0EFF, 8'hFA);

    // Blanking: addresses hold, border index out
    pix1(10'd700, 10'd10, 11'd1199, 14'h0EFF, 8'h00);
    pix1(10'd10, 10'd500, 11'd1199, 14'h0EFF, 8'h00);

    // Back-to-back stream x=0..31 on line 16
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i < 32) begin
        bus.pixel_en = 1'b1; bus.DrawX = 10'(i); bus.DrawY = 10'd16;
      end else begin
        bus.pixel_en = 1'b0;
      end
      #1;
      if (i < 32) chk("stream_map", 32'(bus.map_addr), (i < 16) ? 32'd40 : 32'd41);
      if (i >= 1 && i <= 32) chk("stream_tile", 32'(bus.tile_addr), 32'(ta_of(i - 1, 16)));
      chk("stream_vld", 32'(bus.bg_valid), 32'(i >= 3 && i <= 34));
      if (i >= 3 && i <= 34) begin
        chk("stream_color", 32'(bus.bgColor), 32'(col_of(i - 3, 16)));
        chk("stream_OutX", 32'(bus.OutX), 32'(i - 3));
      end
    end

    // Reset one Clk after a strobe, with another strobe colliding with reset
    @(negedge clk);
    bus.pixel_en = 1'b1; bus.DrawX = 10'd32; bus.DrawY = 10'd32;
    #1 chk("pre_rst_map", 32'(bus.map_addr), 32'd82);
    @(negedge clk);
    rst = 1'b1; bus.DrawX = 10'd48; bus.DrawY = 10'd48;
    #1 chk("rst_dom_map", 32'(bus.map_addr), 32'd82);
    @(negedge clk);
    rst = 1'b0; bus.pixel_en = 1'b0;
    #1;
    chk("post_rst_bg_valid", 32'(bus.bg_valid), 0);
    chk("post_rst_bgColor", 32'(bus.bgColor), 0);
    chk("post_rst_OutX", 32'(bus.OutX), 0);
    chk("post_rst_OutY", 32'(bus.OutY), 0);
    chk("post_rst_map", 32'(bus.map_addr), 0);
    chk("post_rst_tile", 32'(bus.tile_addr), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk("post_rst_quiet", 32'(bus.bg_valid), 0);
    end

`ifdef BG_SCROLL_EN
    // scroll 630 latched at (0,0): x=0 -> 630, x=15 -> 5
    bus.scroll_x = 10'd630;
    pix1(10'd0, 10'd0, 11'd39, ta_of(630, 0), col_of(630, 0));
    pix1(10'd15, 10'd0, 11'd0, 14'h505, col_of(5, 0));
    // Mid-frame change ignored until next frame start
    bus.scroll_x = 10'd100;
    pix1(10'd15, 10'd0, 11'd0, 14'h505, col_of(5, 0));
    pix1(10'd0, 10'd0, 11'd6, ta_of(100, 0), col_of(100, 0));
    pix1(10'd15, 10'd0, 11'd7, ta_of(115, 0), col_of(115, 0));
    // Out-of-range scroll reduced first: 700 -> 60
    bus.scroll_x = 10'd700;
    pix1(10'd0, 10'd0, 11'd3, ta_of(60, 0), col_of(60, 0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
